// File: rtl/mips_dmem_pkg.sv
// Shared types and constants for the byte-serial MIPS data-memory controller.
// Optional build macro used by the controller: MIPS_DMEM_ALIGN_ERR_EN.
package mips_dmem_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TAIL   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // One 32-bit word is moved as four byte beats
    localparam int BEATS  = 4;
    localparam int BEAT_W = 2;

    // Requester indices
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/mips_rr_arbiter2.sv
// Two-requester round-robin arbiter. The pointer names the port that wins a tie
// and always moves to the port that was not granted when a grant is taken.
module mips_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    // One-hot grant: a lone requester wins, a tie goes to the pointed-at port
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // Pointer moves to the other port whenever a grant is consumed
    always_comb begin
        ptr_d = ptr_q;
        if (advance && (|req)) begin
            ptr_d = ~grant[1];
        end
    end

    // Pointer register, favouring port 0 out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mips_dmem_ctrl.sv
// Two-port arbitrated controller in front of a byte-wide synchronous data SRAM.
// Each word access runs as four big-endian byte beats (lowest address = bits 31:24).
// Build macro MIPS_DMEM_ALIGN_ERR_EN adds p0_err/p1_err and rejects misaligned
// requests without touching the SRAM; without it the low address bits are ignored.
module mips_dmem_ctrl
    import mips_dmem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [31:0]       p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic [31:0]       p0_rdata,
    output logic              p0_done,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [31:0]       p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic [31:0]       p1_rdata,
    output logic              p1_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              busy
`ifdef MIPS_DMEM_ALIGN_ERR_EN
    ,
    output logic              p0_err,
    output logic              p1_err
`endif
);

    generate
        if (RD_LAT != 1) begin : g_rd_lat_check
            $error("mips_dmem_ctrl: only RD_LAT = 1 is supported");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W-3:0]   word_q, word_d;
    logic [23:0]         shift_q, shift_d;
    logic [31:0]         p0_rdata_q, p0_rdata_d;
    logic [31:0]         p1_rdata_q, p1_rdata_d;
`ifdef MIPS_DMEM_ALIGN_ERR_EN
    logic                err_q, err_d;
`endif

    logic [1:0]          grant;
    logic                any_grant;
    logic                sel_we;
    logic [31:0]         sel_addr;
    logic [31:0]         sel_wdata;
    logic [7:0]          beat_byte;
    logic                unused_addr_bits;

    mips_rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({p1_req, p0_req}),
        .advance (state_q == IDLE),
        .grant   (grant)
    );

    // Request fields of whichever port the arbiter picks this cycle
    always_comb begin
        any_grant = |grant;
        sel_we    = grant[1] ? p1_we    : p0_we;
        sel_addr  = grant[1] ? p1_addr  : p0_addr;
        sel_wdata = grant[1] ? p1_wdata : p0_wdata;
    end

    // Address bits above the SRAM size and below word granularity are dropped
    assign unused_addr_bits = ^{sel_addr[31:ADDR_W], sel_addr[1:0]};

    // Byte of the latched write word that belongs to the current beat
    always_comb begin
        beat_byte = wdata_q[31:24];
        unique case (beat_q)
            2'd0: beat_byte = wdata_q[31:24];
            2'd1: beat_byte = wdata_q[23:16];
            2'd2: beat_byte = wdata_q[15:8];
            2'd3: beat_byte = wdata_q[7:0];
            default: beat_byte = wdata_q[31:24];
        endcase
    end

    // Next-state logic: grant, four beats, read tail capture, completion
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        shift_d    = shift_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
`ifdef MIPS_DMEM_ALIGN_ERR_EN
        err_d      = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_grant) begin
                    gnt_d   = grant[1];
                    we_d    = sel_we;
                    wdata_d = sel_wdata;
                    word_d  = sel_addr[ADDR_W-1:2];
                    beat_d  = '0;
                    state_d = ACCESS;
`ifdef MIPS_DMEM_ALIGN_ERR_EN
                    err_d   = (sel_addr[1:0] != 2'b00);
                    if (sel_addr[1:0] != 2'b00) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            ACCESS: begin
                if (!we_q && (beat_q != '0)) begin
                    shift_d = {shift_q[15:0], mem_rdata};
                end
                beat_d = beat_q + 1'b1;
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d = we_q ? DONE : TAIL;
                end
            end
            TAIL: begin
                if (gnt_q == PORT_LDR) begin
                    p1_rdata_d = {shift_q, mem_rdata};
                end else begin
                    p0_rdata_d = {shift_q, mem_rdata};
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers; an abandoned transaction leaves the SRAM as is
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            gnt_q      <= PORT_CPU;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            word_q     <= '0;
            shift_q    <= '0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
`ifdef MIPS_DMEM_ALIGN_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            word_q     <= word_d;
            shift_q    <= shift_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
`ifdef MIPS_DMEM_ALIGN_ERR_EN
            err_q      <= err_d;
`endif
        end
    end

    // SRAM strobes decode straight from state so reset silences them at once
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (state_q == ACCESS) begin
            mem_addr = {word_q, beat_q};
            if (we_q) begin
                mem_we    = 1'b1;
                mem_wdata = beat_byte;
            end else begin
                mem_re = 1'b1;
            end
        end
    end

    // Port-facing status and completion outputs
    always_comb begin
        busy     = (state_q != IDLE);
        p0_done  = (state_q == DONE) && (gnt_q == PORT_CPU);
        p1_done  = (state_q == DONE) && (gnt_q == PORT_LDR);
        p0_rdata = p0_rdata_q;
        p1_rdata = p1_rdata_q;
`ifdef MIPS_DMEM_ALIGN_ERR_EN
        p0_err   = p0_done && err_q;
        p1_err   = p1_done && err_q;
`endif
    end

endmodule
